mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage plus MEM/WB pipeline register of the 5-stage RV32I core. Takes the instruction leaving EX, performs loads and stores over the byte-wide memory-controller port, and produces the registered `wb_flag`/`wb_address`/`wb_data` triple consumed by the register file's write port. Holds the pipeline through `stall_req` while a multi-byte access is in flight.

## Interface
Parameters
- none; widths fixed: data 32 bits, register address 5 bits

Ports
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_wb_flag  in  1  instruction writes rd
- ex_wb_address  in  5  rd index
- ex_op  in  4  memory op: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; any other code treated as none
- ex_addr  in  32  ALU result (effective address for loads and stores, rd value otherwise)
- ex_store_data  in  32  rs2 value for stores
- mem_req  out  1  byte transfer request (registered)
- mem_we  out  1  1 = write byte (registered)
- mem_addr  out  32  byte address (registered)
- mem_wdata  out  8  byte to write (registered)
- mem_rdata  in  8  read byte, valid in the cycle `mem_ack`=1
- mem_ack  in  1  current byte transfer completes this cycle
- stall_req  out  1  combinational; upstream holds all ex_* inputs while high
- wb_flag  out  1  registered write enable to register file
- wb_address  out  5  registered rd index
- wb_data  out  32  registered write data

## Operation
- FSM states: IDLE, ACCESS. Byte counter k (2 bits); byte count N = 1 (B/BU), 2 (H/HU), 4 (W).
- IDLE, ex_valid=0: wb_flag<=0 next edge.
- IDLE, ex_valid=1, op none: stall_req=0; next edge wb_flag<=ex_wb_flag & (ex_wb_address!=0), wb_address<=ex_wb_address, wb_data<=ex_addr.
- IDLE, ex_valid=1, memory op: stall_req=1; next edge -> ACCESS, k<=0, mem_req<=1, mem_addr<=ex_addr, mem_we<=store, mem_wdata<=ex_store_data[7:0]; wb_flag<=0 (bubble).
- ACCESS: mem_* held stable until mem_ack. On ack of byte k<N-1: capture byte (loads) into buffer lane k, k<=k+1, mem_addr<=ex_addr+k+1 (mod 2^32, no alignment restriction), mem_wdata<=ex_store_data[8(k+1)+7:8(k+1)], mem_req stays 1.
- ACCESS, ack on byte N-1: stall_req=0 in that cycle; next edge mem_req<=0, -> IDLE, wb outputs registered: loads wb_flag<=ex_wb_flag & (ex_wb_address!=0), wb_data = little-endian assembled value, sign-extended for LB/LH, zero-extended for LBU/LHU; stores wb_flag<=0.
- Every cycle in ACCESS without final ack: stall_req=1, wb_flag<=0.
- x0 never written: wb_flag forced 0 when wb_address would be 0.
- mem_ack in IDLE ignored.

## Timing
- Reset: FSM IDLE, k=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_flag=0, wb_address=0, wb_data=0; byte buffer cleared.
- Reset mid-access: access abandoned; mem_req=0 the cycle after the reset edge; no wb issued. Memory controller shares rst.
- Non-memory op presented in cycle 0: wb outputs valid cycle 1; zero stall.
- Memory op, ack in the first request cycle of each byte: stall_req high cycles 0..N-1, low cycle N; mem_req high cycles 1..N; wb valid cycle N+1; EX/MEM advances at end of cycle N.
- Each ack-wait cycle adds one cycle to the above.
- Back-to-back memory ops: second op sees IDLE in cycle N+1, first request in N+2.

## Test plan
- Reset then ALU op ex_addr=0x1234_5678, rd=5, op none -> stall_req=0; next cycle wb_flag=1, wb_address=5, wb_data=0x1234_5678.
- LW at 0x100, immediate acks, mem bytes 0x78,0x56,0x34,0x12 -> addrs 0x100..0x103 on cycles 1..4, stall_req low cycle 4, wb_data=0x1234_5678 cycle 5.
- LB and LBU at 0x200, byte 0x80 -> wb_data=0xFFFF_FF80 and 0x0000_0080; LH/LHU with 0x8001 -> 0xFFFF_8001 / 0x0000_8001.
- SH 0xAABB_CCDD at 0xFFFF_FFFF, ack delayed 2 cycles per byte -> writes 0xDD@0xFFFF_FFFF, 0xCC@0x0000_0000 (wrap), stall 6 cycles, wb_flag stays 0.
- LW with rd=0 -> bytes fetched, wb_flag=0.
- rst asserted after first byte ack of LW -> mem_req=0 next cycle, all outputs zero, following ALU op completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage and MEM/WB register: runs loads/stores a byte at a time over the memory port.
// Non-memory ops: 1 cycle to wb. Memory ops: N+1 cycles plus one per ack-wait cycle; stall_req holds EX/MEM meanwhile.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_wb_flag,
    input  logic [4:0]  ex_wb_address,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        stall_req,
    output logic        wb_flag,
    output logic [4:0]  wb_address,
    output logic [31:0] wb_data
);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ACCESS = 1'b1;

    logic        state;
    logic [1:0]  k;
    logic [31:0] buffer;

    logic        is_mem;
    logic        is_store;
    logic        signed_ld;
    logic [1:0]  last_k;
    logic        final_ack;
    logic        wb_en;
    logic [1:0]  next_k;
    logic [31:0] assembled;
    logic [31:0] load_value;

    always_comb begin
        is_mem    = 1'b1;
        signed_ld = 1'b0;
        last_k    = 2'd0;
        case (ex_op)
            4'b0001: begin last_k = 2'd0; signed_ld = 1'b1; end
            4'b0010: begin last_k = 2'd1; signed_ld = 1'b1; end
            4'b0011: last_k = 2'd3;
            4'b0100: last_k = 2'd0;
            4'b0101: last_k = 2'd1;
            4'b1001: last_k = 2'd0;
            4'b1010: last_k = 2'd1;
            4'b1011: last_k = 2'd3;
            default: is_mem = 1'b0;
        endcase
    end

    assign is_store  = ex_op[3];
    assign wb_en     = ex_wb_flag && (ex_wb_address != 5'd0);
    assign next_k    = k + 2'd1;
    assign final_ack = (state == S_ACCESS) && mem_ack && (k == last_k);

    // Combinational so EX/MEM can advance in the same cycle the last byte completes.
    always_comb begin
        if (state == S_IDLE)
            stall_req = ex_valid && is_mem;
        else
            stall_req = !final_ack;
    end

    // Final byte goes straight from mem_rdata into the result without a buffer round-trip.
    always_comb begin
        assembled = buffer;
        assembled[{k, 3'b000} +: 8] = mem_rdata;
    end

    always_comb begin
        case (last_k)
            2'd0:    load_value = signed_ld ? {{24{assembled[7]}}, assembled[7:0]}
                                            : {24'd0, assembled[7:0]};
            2'd1:    load_value = signed_ld ? {{16{assembled[15]}}, assembled[15:0]}
                                            : {16'd0, assembled[15:0]};
            default: load_value = assembled;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k          <= 2'd0;
            buffer     <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 8'd0;
            wb_flag    <= 1'b0;
            wb_address <= 5'd0;
            wb_data    <= 32'd0;
        end else if (state == S_IDLE) begin
            wb_flag <= 1'b0;
            if (ex_valid) begin
                if (is_mem) begin
                    state     <= S_ACCESS;
                    k         <= 2'd0;
                    buffer    <= 32'd0;
                    mem_req   <= 1'b1;
                    mem_we    <= is_store;
                    mem_addr  <= ex_addr;
                    mem_wdata <= ex_store_data[7:0];
                end else begin
                    wb_flag    <= wb_en;
                    wb_address <= ex_wb_address;
                    wb_data    <= ex_addr;
                end
            end
        end else begin
            wb_flag <= 1'b0;
            if (mem_ack) begin
                if (k == last_k) begin
                    state   <= S_IDLE;
                    k       <= 2'd0;
                    mem_req <= 1'b0;
                    if (!is_store) begin
                        wb_flag    <= wb_en;
                        wb_address <= ex_wb_address;
                        wb_data    <= load_value;
                    end
                end else begin
                    buffer[{k, 3'b000} +: 8] <= mem_rdata;
                    k         <= next_k;
                    mem_addr  <= ex_addr + {30'd0, next_k};
                    mem_wdata <= ex_store_data[{next_k, 3'b000} +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Transaction-level bench: acts as the byte memory controller and predicts each op's bus and wb results.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_wb_flag;
    logic [4:0]  ex_wb_address;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        stall_req;
    logic        wb_flag;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem_m [logic [31:0]];

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_wb_flag(ex_wb_flag), .ex_wb_address(ex_wb_address),
        .ex_op(ex_op), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_req(stall_req),
        .wb_flag(wb_flag), .wb_address(wb_address), .wb_data(wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0100, 4'b1001: return 1;
            4'b0010, 4'b0101, 4'b1010: return 2;
            4'b0011, 4'b1011:          return 4;
            default:                   return 0;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] v);
        case (op)
            4'b0001: return v[7]  ? (v & 32'hFF)   | 32'hFFFF_FF00 : v & 32'hFF;
            4'b0100: return v & 32'hFF;
            4'b0010: return v[15] ? (v & 32'hFFFF) | 32'hFFFF_0000 : v & 32'hFFFF;
            4'b0101: return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    task automatic idle_cycle();
        ex_valid = 1'b0;
        ex_op    = 4'($urandom);
        mem_ack  = 1'($urandom);
        #1 chk("idle_stall", stall_req, 0);
        @(posedge clk); @(negedge clk);
        chk("idle_wb_flag", wb_flag, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    // Starts and ends on a negedge; the op's wb result is checked on return.
    task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic wbf,
                          input logic [31:0] addr, input logic [31:0] sdata, input int dly,
                          output logic gflag, output logic [31:0] gdata, output int stalls);
        int n;
        int d;
        logic [31:0] v;
        logic exp_flag;
        logic [31:0] exp_data;
        n = nbytes(op);
        stalls = 0;
        v = 32'd0;
        ex_valid = 1'b1; ex_op = op; ex_wb_address = rd; ex_wb_flag = wbf;
        ex_addr = addr; ex_store_data = sdata;
        mem_ack = 1'b0; mem_rdata = 8'($urandom);
        if (n == 0) begin
            mem_ack = 1'($urandom);
            #1 chk("alu_stall", stall_req, 0);
            @(posedge clk); @(negedge clk);
            exp_flag = wbf && (rd != 5'd0);
            exp_data = addr;
        end else begin
            #1 chk("first_stall", stall_req, 1);
            stalls++;
            @(posedge clk); @(negedge clk);
            for (int b = 0; b < n; b++) begin
                d = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
                for (int w = 0; w <= d; w++) begin
                    chk("mem_req", mem_req, 1);
                    chk("mem_addr", mem_addr, addr + 32'(b));
                    chk("mem_we", mem_we, op[3]);
                    if (op[3]) chk("mem_wdata", mem_wdata, sdata[8*b +: 8]);
                    chk("bubble", wb_flag, 0);
                    if (w < d) begin
                        mem_ack = 1'b0;
                        mem_rdata = 8'($urandom);
                        #1 chk("wait_stall", stall_req, 1);
                        stalls++;
                    end else begin
                        mem_ack = 1'b1;
                        if (op[3]) mem_m[mem_addr] = mem_wdata;
                        else begin
                            mem_rdata = rd_byte(addr + 32'(b));
                            v[8*b +: 8] = mem_rdata;
                        end
                        #1 chk("ack_stall", stall_req, 32'(b != n - 1));
                        if (b != n - 1) stalls++;
                    end
                    @(posedge clk); @(negedge clk);
                end
            end
            mem_ack = 1'b0;
            chk("req_drop", mem_req, 0);
            exp_flag = !op[3] && wbf && (rd != 5'd0);
            exp_data = extend(op, v);
        end
        chk("wb_flag", wb_flag, exp_flag);
        if (exp_flag) begin
            chk("wb_address", wb_address, rd);
            chk("wb_data", wb_data, exp_data);
        end
        gflag = wb_flag;
        gdata = wb_data;
        ex_valid = 1'b0;
    endtask

    logic        gf;
    logic [31:0] gd;
    int          st;
    logic [3:0]  ops [12];

    initial begin
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA, 4'hB, 4'h6, 4'h8, 4'hF};
        rst = 1'b1; ex_valid = 1'b0; ex_wb_flag = 1'b0; ex_wb_address = 5'd0;
        ex_op = 4'd0; ex_addr = 32'd0; ex_store_data = 32'd0;
        mem_rdata = 8'd0; mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_wb_flag", wb_flag, 0);
        chk("rst_wb_address", wb_address, 0);
        chk("rst_wb_data", wb_data, 0);

        run_op(4'h0, 5'd5, 1'b1, 32'h1234_5678, 32'd0, 0, gf, gd, st);
        chk("alu_lit_flag", gf, 1);
        chk("alu_lit_data", gd, 32'h1234_5678);
        chk("alu_lit_stall", st, 0);

        mem_m[32'h100] = 8'h78; mem_m[32'h101] = 8'h56;
        mem_m[32'h102] = 8'h34; mem_m[32'h103] = 8'h12;
        run_op(4'h3, 5'd3, 1'b1, 32'h100, 32'd0, 0, gf, gd, st);
        chk("lw_lit_data", gd, 32'h1234_5678);
        chk("lw_lit_stall", st, 4);

        mem_m[32'h200] = 8'h80;
        run_op(4'h1, 5'd4, 1'b1, 32'h200, 32'd0, 0, gf, gd, st);
        chk("lb_lit", gd, 32'hFFFF_FF80);
        run_op(4'h4, 5'd4, 1'b1, 32'h200, 32'd0, 1, gf, gd, st);
        chk("lbu_lit", gd, 32'h0000_0080);
        mem_m[32'h300] = 8'h01; mem_m[32'h301] = 8'h80;
        run_op(4'h2, 5'd6, 1'b1, 32'h300, 32'd0, 0, gf, gd, st);
        chk("lh_lit", gd, 32'hFFFF_8001);
        run_op(4'h5, 5'd6, 1'b1, 32'h300, 32'd0, 0, gf, gd, st);
        chk("lhu_lit", gd, 32'h0000_8001);

        run_op(4'hA, 5'd9, 1'b1, 32'hFFFF_FFFF, 32'hAABB_CCDD, 2, gf, gd, st);
        chk("sh_lit_stall", st, 6);
        chk("sh_lit_flag", gf, 0);
        chk("sh_lit_b0", rd_byte(32'hFFFF_FFFF), 32'hDD);
        chk("sh_lit_wrap", rd_byte(32'h0000_0000), 32'hCC);
        run_op(4'h2, 5'd9, 1'b1, 32'hFFFF_FFFF, 32'd0, 0, gf, gd, st);
        chk("sh_readback", gd, 32'hFFFF_CCDD);

        run_op(4'h3, 5'd0, 1'b1, 32'h100, 32'd0, 0, gf, gd, st);
        chk("lw_x0_flag", gf, 0);

        // Reset after the first byte ack of an LW.
        ex_valid = 1'b1; ex_op = 4'h3; ex_wb_address = 5'd7; ex_wb_flag = 1'b1;
        ex_addr = 32'h500; mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'h11;
        @(posedge clk); @(negedge clk);
        chk("mid_addr1", mem_addr, 32'h501);
        mem_ack = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_flag", wb_flag, 0);
        chk("mid_rst_wbaddr", wb_address, 0);
        chk("mid_rst_wbdata", wb_data, 0);
        idle_cycle();
        run_op(4'h0, 5'd8, 1'b1, 32'hCAFE_F00D, 32'd0, 0, gf, gd, st);
        chk("post_rst_alu", gd, 32'hCAFE_F00D);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'h0000_0400 + 32'($urandom_range(0, 15));
                1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = $urandom;
            endcase
            run_op(ops[$urandom_range(0, 11)], 5'($urandom), 1'($urandom), a, $urandom, -1,
                   gf, gd, st);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
